// File: rtl/result_uart_streamer_pkg.sv
// Shared codes for the result streamer: global processing states, UART framing
// constants, the default sync header and the streamer FSM encoding.
package result_uart_streamer_pkg;

  localparam logic [2:0] GS_LOAD       = 3'd0;
  localparam logic [2:0] GS_BOX_FILTER = 3'd1;
  localparam logic [2:0] GS_TRANSMIT   = 3'd2;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT
  } fsm_t;

endpackage

// File: rtl/result_uart_streamer_tx.sv
// UART 8N1 transmitter: start bit on the cycle after load, done pulses in the
// last cycle of the stop bit. Loads arriving while busy are ignored.
module uart_tx_core
  import result_uart_streamer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       not_reset,
  input  logic       iLoad,
  input  logic [7:0] iData,
  output logic       oTx,
  output logic       oBusy,
  output logic       oDone
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [BW-1:0]              baud;
  logic [3:0]                 bit_idx;
  logic [UART_FRAME_BITS-1:0] frame;
  logic                       busy;
  logic                       last_clk;

  assign last_clk = (baud == BW'(CLKS_PER_BIT - 1));
  assign oDone    = busy && last_clk && (bit_idx == 4'(UART_FRAME_BITS - 1));
  // Busy already in the load cycle so the caller never sees a gap.
  assign oBusy    = busy | iLoad;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      oTx     <= 1'b1;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      frame   <= '1;
    end else if (!busy) begin
      if (iLoad) begin
        frame   <= {1'b1, iData, 1'b0};
        oTx     <= 1'b0;
        busy    <= 1'b1;
        baud    <= '0;
        bit_idx <= '0;
      end
    end else if (last_clk) begin
      baud <= '0;
      if (oDone) begin
        busy <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        frame   <= {1'b1, frame[UART_FRAME_BITS-1:1]};
        oTx     <= frame[1];
      end
    end else begin
      baud <= baud + BW'(1);
    end
  end

endmodule

// File: rtl/result_uart_streamer.sv
// Streams the binarized result memory over UART: sync byte, then 8 pixels per byte
// (first pixel in bit 7) in raster order; sticky finished after the last stop bit.
module result_uart_streamer
  import result_uart_streamer_pkg::*;
#(
  parameter int         WIDTH_BITS   = 8,
  parameter int         HEIGHT_BITS  = 8,
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [2:0] ACTIVE_STATE = GS_TRANSMIT,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                   clock,
  input  logic                   not_reset,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  input  logic [7:0]             iResultData,
  input  logic [2:0]             global_state,
  output logic                   oTx,
  output logic                   oBusy,
  output logic                   finished
);

  localparam int PB = WIDTH_BITS + HEIGHT_BITS;

  fsm_t          state;
  logic [PB-1:0] pos;
  logic [PB-1:0] addr;
  logic [3:0]    fcnt;
  logic [7:0]    shreg;
  logic [7:0]    tx_byte;
  logic          header_sent;
  logic          sending_header;
  logic          tx_load;
  logic          tx_done;
  logic          active;

  assign active                   = (global_state == ACTIVE_STATE);
  assign {oResultRow, oResultCol} = addr;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state          <= IDLE;
      pos            <= '0;
      addr           <= '0;
      fcnt           <= '0;
      shreg          <= '0;
      tx_byte        <= '0;
      header_sent    <= 1'b0;
      sending_header <= 1'b0;
      tx_load        <= 1'b0;
      finished       <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      case (state)
        IDLE: begin
          if (active && !finished) begin
            if (!header_sent) begin
              tx_byte        <= SYNC_BYTE;
              sending_header <= 1'b1;
              tx_load        <= 1'b1;
              state          <= SEND;
            end else begin
              addr  <= pos;
              fcnt  <= '0;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          // Read data lags the address by one cycle, so capture runs on fcnt 1..8.
          if (fcnt != 4'd0) shreg <= {shreg[6:0], |iResultData};
          if (fcnt < 4'd7)  addr  <= addr + PB'(1);
          if (fcnt == 4'd8) begin
            pos            <= pos + PB'(8);
            tx_byte        <= {shreg[6:0], |iResultData};
            sending_header <= 1'b0;
            tx_load        <= 1'b1;
            fcnt           <= '0;
            state          <= SEND;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            if (sending_header) header_sent <= 1'b1;
            // pos has already wrapped to zero once the final byte was fetched.
            if (!sending_header && (pos == '0)) begin
              finished <= 1'b1;
              state    <= IDLE;
            end else if (active) begin
              addr  <= pos;
              fcnt  <= '0;
              state <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock    (clock),
    .not_reset(not_reset),
    .iLoad    (tx_load),
    .iData    (tx_byte),
    .oTx      (oTx),
    .oBusy    (oBusy),
    .oDone    (tx_done)
  );

endmodule

// File: tb/tb_result_uart_streamer.sv
// Scoreboard bench: expected bytes queued from a pixel-packing model, a UART
// decoder thread pops and compares each received frame.
module tb_result_uart_streamer;
  import result_uart_streamer_pkg::*;

  localparam int WB     = 4;
  localparam int HB     = 1;
  localparam int CPB    = 4;
  localparam int NPIX   = 32;
  localparam int NBYTES = 4;

  logic          clock = 1'b0;
  logic          not_reset = 1'b0;
  logic [WB-1:0] col;
  logic [HB-1:0] row;
  logic [7:0]    rdata = 8'h00;
  logic [2:0]    gs = 3'd0;
  logic          tx, busy, fin;
  logic [7:0]    mem [NPIX];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int frames_seen = 0;
  int frame_end_cyc = 0;
  int fin_rise_cyc = 0;
  logic [7:0] exp_q[$];
  int addr_v[$];
  int addr_c[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rdata <= mem[{row, col}];

  result_uart_streamer #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CLKS_PER_BIT(CPB),
    .ACTIVE_STATE(3'd2), .SYNC_BYTE(8'hA5)
  ) dut (
    .clock(clock), .not_reset(not_reset), .oResultCol(col), .oResultRow(row),
    .iResultData(rdata), .global_state(gs), .oTx(tx), .oBusy(busy), .finished(fin)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Pixel i of byte b lands in bit 7-i; any non-zero pixel value is a one.
  function automatic logic [7:0] model_byte(int b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = (mem[8*b+i] != 8'h00);
    return r;
  endfunction

  task automatic push_expected();
    exp_q.push_back(8'hA5);
    for (int b = 0; b < NBYTES; b++) exp_q.push_back(model_byte(b));
  endtask

  task automatic mon_loop();
    int mcnt = 0;
    int brun = 0;
    int prev_addr = 0;
    int cur;
    logic [9:0] bits = '0;
    bit inf = 0, tbad = 0, prev_busy = 0, prev_fin = 0;
    forever begin
      @(negedge clock);
      cur = int'({row, col});
      if (!not_reset) begin
        inf = 0; brun = 0; prev_busy = 0;
      end else begin
        if (cur != prev_addr) begin addr_v.push_back(cur); addr_c.push_back(cyc); end
        if (fin && !prev_fin) fin_rise_cyc = cyc;
        if (busy) brun++;
        else if (prev_busy) begin chk("busy_width", brun, 41); brun = 0; end
        prev_busy = busy;
        if (!inf) begin
          if (tx == 1'b0) begin inf = 1; mcnt = 1; bits[0] = 1'b0; tbad = 0; frames_seen++; end
        end else begin
          if (mcnt % CPB == 0) bits[mcnt/CPB] = tx;
          else if (tx != bits[mcnt/CPB]) tbad = 1;
          mcnt++;
          if (mcnt == 10*CPB) begin
            inf = 0;
            frame_end_cyc = cyc;
            chk("frame_timing_stop", {30'd0, tbad, bits[9]}, 32'd1);
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_frame: got byte %0h, expected no frame", bits[8:1]);
            end else begin
              chk("byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
            end
          end
        end
      end
      prev_fin = fin;
      prev_addr = cur;
    end
  endtask

  task automatic do_reset(logic [2:0] g);
    @(negedge clock);
    not_reset = 1'b0;
    gs = g;
    exp_q.delete();
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fin", fin, 0);
    chk("rst_addr", {row, col}, 0);
    repeat (3) @(negedge clock);
    addr_v.delete();
    addr_c.delete();
    not_reset = 1'b1;
  endtask

  task automatic wait_fin(int budget);
    int k = 0;
    while (!fin && k < budget) begin @(negedge clock); k++; end
    chk("finished_timeout", fin, 1);
  endtask

  task automatic wait_frames(int target, int budget);
    int k = 0;
    while (frames_seen < target && k < budget) begin @(negedge clock); k++; end
    chk("frame_wait_timeout", frames_seen, target);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NPIX; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    int n, base, lows;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    fork mon_loop(); join_none

    // Alternating FF/00 image gives AA bytes; finished one cycle after last stop bit.
    for (int i = 0; i < NPIX; i++) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    do_reset(3'd2);
    push_expected();
    wait_fin(3000);
    chk("all_bytes_1", exp_q.size(), 0);
    chk("fin_latency", fin_rise_cyc - frame_end_cyc, 1);
    n = addr_v.size();
    repeat (100) @(negedge clock);
    chk("no_reread", addr_v.size(), n);
    chk("fin_sticky", fin, 1);

    // Memory = index: byte 0 is 7F, addresses step by one on consecutive fetch cycles.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    do_reset(3'd2);
    push_expected();
    wait_fin(3000);
    chk("all_bytes_2", exp_q.size(), 0);
    chk("addr_count", addr_v.size(), NPIX - 1);
    if (addr_v.size() == NPIX - 1) begin
      for (int v = 1; v < NPIX; v++) begin
        chk("addr_value", addr_v[v-1], v);
        if (v % 8 != 0 && v != 1) chk("addr_consecutive", addr_c[v-1] - addr_c[v-2], 1);
      end
    end

    // Leave the active state during byte 1, then resume without a new header.
    rand_mem();
    do_reset(3'd2);
    push_expected();
    base = frames_seen;
    wait_frames(base + 3, 2000);
    gs = 3'd0;
    n = addr_v.size();
    repeat (200) @(negedge clock);
    chk("pause_no_frame", frames_seen, base + 3);
    chk("pause_tx_idle", tx, 1);
    chk("pause_no_addr", addr_v.size(), n);
    chk("pause_remaining", exp_q.size(), 2);
    chk("pause_not_fin", fin, 0);
    gs = 3'd2;
    wait_fin(3000);
    chk("all_bytes_4", exp_q.size(), 0);
    chk("frames_total_4", frames_seen, base + 5);

    // Reset during data bit 3 of byte 0, then a full restart with the header.
    rand_mem();
    do_reset(3'd2);
    push_expected();
    base = frames_seen;
    wait_frames(base + 2, 2000);
    repeat (17) @(negedge clock);
    #1 not_reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_fin", fin, 0);
    repeat (3) @(negedge clock);
    exp_q.delete();
    push_expected();
    not_reset = 1'b1;
    wait_fin(3000);
    chk("all_bytes_5", exp_q.size(), 0);

    // Inactive state: nothing moves.
    do_reset(3'd1);
    base = frames_seen;
    n = addr_v.size();
    lows = 0;
    repeat (1000) begin @(negedge clock); if (!tx) lows++; end
    chk("inactive_tx_low", lows, 0);
    chk("inactive_frames", frames_seen, base);
    chk("inactive_addr", addr_v.size(), n);
    chk("inactive_fin", fin, 0);

    // Random images.
    for (int r = 0; r < 2; r++) begin
      rand_mem();
      do_reset(3'd2);
      push_expected();
      wait_fin(3000);
      chk("all_bytes_rand", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
